// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared FSM states, port ids and MEM_LAT range check for mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;
  function automatic logic mem_lat_ok(int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational grant select; round-robin on ties when MEM_ARB_RR_EN is defined,
// otherwise the data port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic gnt_valid,
  output logic gnt_port
);
  assign gnt_valid = i_req | d_req;
`ifdef MEM_ARB_RR_EN
  assign gnt_port = (i_req && d_req) ? ~last_grant : (d_req ? PORT_D : PORT_IF);
`else
  assign gnt_port = d_req ? PORT_D : PORT_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF fetch and MEM data accesses.
// MEM_ARB_RR_EN selects round-robin tie breaking instead of fixed data-port priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end
  state_t            state_q;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              gnt_valid;
  logic              gnt_port;
`ifdef MEM_ARB_RR_EN
  logic              last_q;
`endif
  mem_arb_pick u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
`ifdef MEM_ARB_RR_EN
    .last_grant(last_q),
`endif
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );
  // Memory sees only latched values, so requester inputs may change once granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      port_q    <= PORT_IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_q    <= '0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= PORT_IF;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt_valid) begin
          port_q   <= gnt_port;
          addr_q   <= (gnt_port == PORT_D) ? d_addr : i_addr;
          wdata_q  <= (gnt_port == PORT_D) ? d_wdata : '0;
          mem_we_q <= (gnt_port == PORT_D) && d_we;
          mem_re_q <= !((gnt_port == PORT_D) && d_we);
          wait_q   <= 4'(MEM_LAT - 1);
          state_q  <= ACCESS;
`ifdef MEM_ARB_RR_EN
          last_q   <= gnt_port;
`endif
        end
        ACCESS: if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
        else begin
          if (mem_re_q && port_q == PORT_D) d_rdata_q <= mem_rdata;
          if (mem_re_q && port_q == PORT_IF) i_rdata_q <= mem_rdata;
          i_ack_q  <= (port_q == PORT_IF);
          d_ack_q  <= (port_q == PORT_D);
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          state_q  <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks on a MEM_LAT=1 and a MEM_LAT=3 arbiter sharing stimulus.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic        i_ack1, d_ack1, mem_we1, mem_re1;
  logic        i_ack3, d_ack3, mem_we3, mem_re3;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_re(mem_re1), .mem_rdata(mem_rdata)
  );
  mem_port_arbiter #(.MEM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ack(i_ack3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata3), .d_ack(d_ack3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_re(mem_re3), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    i_req = 1'b1; i_addr = 32'h80;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_re1 !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re1: got %b want 0", mem_re1); end
    n_checks++; if (mem_addr3 !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr3: got %h want 0", mem_addr3); end
    n_checks++; if ({i_ack1, d_ack1, mem_we1, i_ack3, d_ack3, mem_we3, mem_re3} !== 7'b0) begin
      n_fail++; $display("FAIL rst_ctrl: got %b want 0000000", {i_ack1, d_ack1, mem_we1, i_ack3, d_ack3, mem_we3, mem_re3}); end
    n_checks++; if ({i_rdata1, d_rdata1, mem_wdata1} !== 96'h0) begin
      n_fail++; $display("FAIL rst_data: got %h want 0", {i_rdata1, d_rdata1, mem_wdata1}); end
    i_req = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_lat1();
    do_reset();
    i_req = 1'b1; i_addr = 32'h10; mem_rdata = 32'h00A00093;
    tick();
    n_checks++; if ({mem_re1, mem_we1, i_ack1} !== 3'b100) begin n_fail++; $display("FAIL f1_c1_ctrl: got %b want 100", {mem_re1, mem_we1, i_ack1}); end
    n_checks++; if (mem_addr1 !== 32'h10) begin n_fail++; $display("FAIL f1_c1_addr: got %h want 00000010", mem_addr1); end
    tick();
    n_checks++; if ({i_ack1, d_ack1, mem_re1} !== 3'b100) begin n_fail++; $display("FAIL f1_c2_ack: got %b want 100", {i_ack1, d_ack1, mem_re1}); end
    n_checks++; if (i_rdata1 !== 32'h00A00093) begin n_fail++; $display("FAIL f1_c2_rdata: got %h want 00a00093", i_rdata1); end
    i_req = 1'b0;
    tick();
    n_checks++; if ({i_ack1, mem_re1} !== 2'b00) begin n_fail++; $display("FAIL f1_c3_idle: got %b want 00", {i_ack1, mem_re1}); end
  endtask

  task automatic test_store_lat3();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_rdata = 32'h12345678;
    tick(); tick(); tick(); tick();
    n_checks++; if ({d_ack3, d_rdata3} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL st_load: got %b/%h want 1/12345678", d_ack3, d_rdata3); end
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; mem_rdata = 32'h0BADF00D;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if ({mem_we3, mem_re3, d_ack3} !== 3'b100) begin n_fail++; $display("FAIL st_c%0d_ctrl: got %b want 100", k, {mem_we3, mem_re3, d_ack3}); end
      n_checks++; if ({mem_addr3, mem_wdata3} !== {32'h40, 32'hDEADBEEF}) begin n_fail++; $display("FAIL st_c%0d_bus: got %h/%h want 00000040/deadbeef", k, mem_addr3, mem_wdata3); end
    end
    tick();
    n_checks++; if ({d_ack3, i_ack3, mem_we3} !== 3'b100) begin n_fail++; $display("FAIL st_c4_ack: got %b want 100", {d_ack3, i_ack3, mem_we3}); end
    n_checks++; if (d_rdata3 !== 32'h12345678) begin n_fail++; $display("FAIL st_c4_rdata: got %h want 12345678", d_rdata3); end
    d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_fixed_tie();
    do_reset();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; mem_rdata = 32'hCAFE0001;
    tick();
    n_checks++; if (mem_addr1 !== 32'h20) begin n_fail++; $display("FAIL tie_c1_addr: got %h want 00000020", mem_addr1); end
    tick();
    n_checks++; if ({d_ack1, i_ack1} !== 2'b10) begin n_fail++; $display("FAIL tie_c2_ack: got %b want 10", {d_ack1, i_ack1}); end
    n_checks++; if (d_rdata1 !== 32'hCAFE0001) begin n_fail++; $display("FAIL tie_c2_rdata: got %h want cafe0001", d_rdata1); end
    d_req = 1'b0; mem_rdata = 32'hCAFE0002;
    tick();
    n_checks++; if ({d_ack1, i_ack1, mem_re1} !== 3'b000) begin n_fail++; $display("FAIL tie_c3_idle: got %b want 000", {d_ack1, i_ack1, mem_re1}); end
    tick();
    n_checks++; if ({mem_re1, mem_addr1} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL tie_c4_if: got %b/%h want 1/00000010", mem_re1, mem_addr1); end
    tick();
    n_checks++; if ({i_ack1, d_ack1, i_rdata1} !== {2'b10, 32'hCAFE0002}) begin n_fail++; $display("FAIL tie_c5_ack: got %b/%h want 10/cafe0002", {i_ack1, d_ack1}, i_rdata1); end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr [4];
`ifdef MEM_ARB_RR_EN
    exp_addr = '{32'h20, 32'h10, 32'h20, 32'h10};
`else
    exp_addr = '{32'h20, 32'h20, 32'h20, 32'h20};
`endif
    do_reset();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; mem_rdata = 32'h55;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if ({mem_re1, mem_addr1} !== {1'b1, exp_addr[k]}) begin n_fail++; $display("FAIL b2b_%0d_grant: got %b/%h want 1/%h", k, mem_re1, mem_addr1, exp_addr[k]); end
      tick();
      n_checks++; if ({d_ack1, i_ack1} !== {exp_addr[k] == 32'h20, exp_addr[k] == 32'h10}) begin
        n_fail++; $display("FAIL b2b_%0d_ack: got %b want %b", k, {d_ack1, i_ack1}, {exp_addr[k] == 32'h20, exp_addr[k] == 32'h10}); end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h11112222;
    tick(); tick();
    n_checks++; if (mem_we3 !== 1'b1) begin n_fail++; $display("FAIL rms_pre_we: got %b want 1", mem_we3); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_we3, mem_re3, mem_addr3} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL rms_async: got %b/%h want 00/0", {mem_we3, mem_re3}, mem_addr3); end
    d_req = 1'b0; d_we = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if ({d_ack3, mem_we3} !== 2'b00) begin n_fail++; $display("FAIL rms_idle_%0d: got %b want 00", k, {d_ack3, mem_we3}); end
    end
    d_req = 1'b1; d_we = 1'b1;
    tick();
    n_checks++; if ({mem_we3, mem_wdata3} !== {1'b1, 32'h11112222}) begin n_fail++; $display("FAIL rms_reissue: got %b/%h want 1/11112222", mem_we3, mem_wdata3); end
    tick(); tick(); tick();
    n_checks++; if (d_ack3 !== 1'b1) begin n_fail++; $display("FAIL rms_ack: got %b want 1", d_ack3); end
    d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    i_req = 1'b1; i_addr = 32'h30; mem_rdata = 32'h00000013;
    tick();
    i_req = 1'b0;
    tick(); tick();
    n_checks++; if ({i_ack3, mem_re3} !== 2'b01) begin n_fail++; $display("FAIL drop_c3: got %b want 01", {i_ack3, mem_re3}); end
    tick();
    n_checks++; if ({i_ack3, i_rdata3} !== {1'b1, 32'h00000013}) begin n_fail++; $display("FAIL drop_c4_ack: got %b/%h want 1/00000013", i_ack3, i_rdata3); end
    tick(); tick();
    n_checks++; if ({i_ack3, mem_re3, mem_we3} !== 3'b000) begin n_fail++; $display("FAIL drop_c6_idle: got %b want 000", {i_ack3, mem_re3, mem_we3}); end
  endtask

  initial begin
    test_reset();
    test_fetch_lat1();
    test_store_lat3();
    test_fixed_tie();
    test_back_to_back();
    test_reset_mid_store();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
